// File: rtl/adder_pkg.sv
// Shared elaboration helpers for the pipelined prefix adder: width legality,
// prefix depth and end-to-end latency.
package adder_pkg;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return result;
    endfunction

    function automatic bit width_legal(input int width);
        return (width >= 4) && (width <= 64) && ((width & (width - 1)) == 0);
    endfunction

    // PIPE=1 registers the pre-processed operands, each inner level and the output.
    function automatic int latency_of(input int width, input bit pipe);
        return pipe ? clog2(width) + 1 : 1;
    endfunction

endpackage

// File: rtl/prefix_cell.sv
// Sklansky tree node: merges a high group (gh, ph) with the adjacent lower
// group (gl, pl) into one generate/propagate pair.
module prefix_cell (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic g,
    output logic p
);

    assign g = gh | (ph & gl);
    assign p = ph & pl;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Add/subtract unit built on a Sklansky carry tree, optionally pipelined per
// level, with a valid/ready stream interface that freezes wholesale on stall.
module pipelined_prefix_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = clog2(WIDTH);

    genvar gi, gj;

    if (!width_legal(WIDTH)) begin : g_width_check
        $error("pipelined_prefix_adder: WIDTH must be a power of two in 4..64");
    end

    logic             out_valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             advance;

    assign advance  = ~(out_valid_reg & ~out_ready);
    assign in_ready = advance;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] pre_p;
    logic [WIDTH-1:0] pre_g;
    logic             pre_c0;

    assign b_eff  = sub ? ~b : b;
    assign pre_c0 = sub | cin;
    assign pre_p  = a ^ b_eff;
    // Carry-in is folded into bit 0's generate so the tree yields G[i:0] including c0.
    assign pre_g  = {a[WIDTH-1:1] & b_eff[WIDTH-1:1], (a[0] & b_eff[0]) | (pre_p[0] & pre_c0)};

    logic [WIDTH-1:0] lvl_g_in  [LEVELS];
    logic [WIDTH-1:0] lvl_p_in  [LEVELS];
    logic [WIDTH-1:0] lvl_g_out [LEVELS];
    logic [WIDTH-1:0] lvl_p_out [LEVELS];

    logic [WIDTH-1:0] end_x;
    logic             end_c0;
    logic             end_v;

    for (gi = 0; gi < LEVELS; gi++) begin : g_level
        for (gj = 0; gj < WIDTH; gj++) begin : g_bit
            if (((gj >> gi) & 1) == 1) begin : g_cell
                localparam int LOW = ((gj >> gi) << gi) - 1;
                prefix_cell u_cell (
                    .gh (lvl_g_in[gi][gj]),
                    .ph (lvl_p_in[gi][gj]),
                    .gl (lvl_g_in[gi][LOW]),
                    .pl (lvl_p_in[gi][LOW]),
                    .g  (lvl_g_out[gi][gj]),
                    .p  (lvl_p_out[gi][gj])
                );
            end else begin : g_pass
                assign lvl_g_out[gi][gj] = lvl_g_in[gi][gj];
                assign lvl_p_out[gi][gj] = lvl_p_in[gi][gj];
            end
        end
    end

    if (PIPE != 0) begin : g_pipe
        logic [WIDTH-1:0]  st_g_reg [LEVELS];
        logic [WIDTH-1:0]  st_p_reg [LEVELS];
        logic [WIDTH-1:0]  st_x_reg [LEVELS];
        logic [LEVELS-1:0] st_c0_reg;
        logic [LEVELS-1:0] st_v_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                st_v_reg <= '0;
            end else if (advance) begin
                st_v_reg <= {st_v_reg[LEVELS-2:0], in_valid};
            end
        end

        // Stage 0 holds the pre-processed operands; stage k holds level k-1's output.
        always_ff @(posedge clk) begin
            if (advance) begin
                st_g_reg[0] <= pre_g;
                st_p_reg[0] <= pre_p;
                st_x_reg[0] <= pre_p;
                st_c0_reg   <= {st_c0_reg[LEVELS-2:0], pre_c0};
                for (int k = 1; k < LEVELS; k++) begin
                    st_g_reg[k] <= lvl_g_out[k-1];
                    st_p_reg[k] <= lvl_p_out[k-1];
                    st_x_reg[k] <= st_x_reg[k-1];
                end
            end
        end

        for (gi = 0; gi < LEVELS; gi++) begin : g_feed
            assign lvl_g_in[gi] = st_g_reg[gi];
            assign lvl_p_in[gi] = st_p_reg[gi];
        end

        assign end_x  = st_x_reg[LEVELS-1];
        assign end_c0 = st_c0_reg[LEVELS-1];
        assign end_v  = st_v_reg[LEVELS-1];
    end else begin : g_comb
        for (gi = 0; gi < LEVELS; gi++) begin : g_feed
            if (gi == 0) begin : g_first
                assign lvl_g_in[gi] = pre_g;
                assign lvl_p_in[gi] = pre_p;
            end else begin : g_chain
                assign lvl_g_in[gi] = lvl_g_out[gi-1];
                assign lvl_p_in[gi] = lvl_p_out[gi-1];
            end
        end

        assign end_x  = pre_p;
        assign end_c0 = pre_c0;
        assign end_v  = in_valid;
    end

    logic [WIDTH-1:0] g_fin;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             ovf_next;

    assign g_fin     = lvl_g_out[LEVELS-1];
    assign sum_next  = end_x ^ {g_fin[WIDTH-2:0], end_c0};
    assign cout_next = g_fin[WIDTH-1];
    assign ovf_next  = g_fin[WIDTH-1] ^ g_fin[WIDTH-2];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (advance) begin
            out_valid_reg <= end_v;
            sum_reg       <= sum_next;
            cout_reg      <= cout_next;
            ovf_reg       <= ovf_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: doc/pipelined_prefix_adder.md
PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand width; SHALL be a power of two, 4..64; elaboration fails otherwise.
REQ-002 Parameter PIPE, default 1: 1 = register after every prefix level; 0 = output register only.
REQ-003 Derived constant LEVELS = clog2(WIDTH); LATENCY = LEVELS+1 when PIPE=1, 1 when PIPE=0.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  operand beat present.
REQ-007 in_ready  out  1  block can accept a beat this cycle.
REQ-008 a, b  in  WIDTH each  operands.
REQ-009 cin  in  1  carry-in; ignored when sub=1.
REQ-010 sub  in  1  0 = a+b+cin; 1 = a-b, computed as a+~b+1.
REQ-011 out_valid  out  1  result beat present.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 sum  out  WIDTH  result bits.
REQ-014 cout  out  1  carry out of bit WIDTH-1; for sub, 1 means no borrow.
REQ-015 ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-016 Pre-processing SHALL form p=a^b', g=a&b', with b'=sub?~b:b, and inject the carry-in as the level-0 generate term (c0=sub?1:cin).
REQ-017 Carry computation SHALL use a Sklansky (divide-and-conquer) prefix tree of exactly LEVELS levels; cells compute g=gh|(ph&gl), p=ph&pl.
REQ-018 Post-processing SHALL form sum[i]=p[i]^G[i-1:0] and cout=G[WIDTH-1:0]; the result SHALL equal (a+b'+c0) mod 2^(WIDTH+1) bit-exactly.
REQ-019 A beat transfers in when in_valid&in_ready; out when out_valid&out_ready.
REQ-020 Stall = out_valid & ~out_ready; in_ready = ~stall (combinational, no dependency on in_valid).
REQ-021 During stall every pipeline register, including valid bits, SHALL hold; no beat is dropped or duplicated.
REQ-022 Without stall each valid bit advances one stage per cycle; a beat accepted in cycle t appears with out_valid=1 in cycle t+LATENCY.
REQ-023 Bubbles (in_valid=0) SHALL propagate as invalid stages; sum/cout/ovf are don't-care when out_valid=0.
REQ-024 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-025 Results SHALL leave in acceptance order; sub/cin travel with their beat.
REQ-026 out_valid/sum/cout/ovf SHALL be driven directly from registers.

Reset
REQ-027 While rst=1: all valid bits 0, out_valid=0, sum=0, cout=0, ovf=0, in_ready=1 in the following cycle.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; a beat presented with in_valid=1 during a reset cycle SHALL NOT be accepted.
REQ-029 Datapath registers other than outputs need not be reset; only valid bits and outputs are reset.

Structure
REQ-030 Shared package adder_pkg SHALL hold the clog2 function, WIDTH legality check and latency constant formula.
REQ-031 One sub-module prefix_cell (g/p combine, 2-in to 1-out pair) SHALL be instantiated by generate loops; no other sub-modules.

Verification
REQ-032 WIDTH=4, PIPE=1, a=4'hF, b=4'h1, cin=0, sub=0 -> after 3 cycles out_valid=1, sum=4'h0, cout=1, ovf=0.
REQ-033 WIDTH=16, sub=1, a=16'h8000, b=16'h0001 -> sum=16'h7FFF, cout=1, ovf=1, latency 5.
REQ-034 WIDTH=16, 100 back-to-back random beats, out_ready=1 -> 100 results in order, one per cycle, matching the reference model.
REQ-035 Hold out_ready=0 for 7 cycles with pipeline full -> in_ready=0, outputs stable, zero loss; release -> results resume in order.
REQ-036 Assert rst with 3 beats in flight -> next cycle out_valid=0, no stale beat ever emerges; first post-reset beat arrives LATENCY cycles after acceptance.
REQ-037 PIPE=0, WIDTH=64, a=all ones, b=0, cin=1 -> 1-cycle latency, sum=0, cout=1.
